// File: rtl/bist_sig_checker.sv
// BIST sequencer and signature checker driving a MISR: clear, N_PATTERNS compaction cycles, compare.
// Define BIST_SIG_CAPTURE_EN to add the sig_captured output holding the last checked signature.
module bist_sig_checker #(
    parameter int unsigned SIG_W      = 16,
    parameter int unsigned N_PATTERNS = 256,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] misr_sig,
    input  logic [SIG_W-1:0] golden_sig,
    output logic             misr_clear,
    output logic             misr_enable,
    output logic             pattern_adv,
    output logic [CNT_W-1:0] pattern_idx,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef BIST_SIG_CAPTURE_EN
    output logic             fail,
    output logic [SIG_W-1:0] sig_captured
`else
    output logic             fail
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StCheck,
        StDone
    } state_e;

    localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_PATTERNS - 1);
    localparam logic [CNT_W-1:0] IdxOne  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
`ifdef BIST_SIG_CAPTURE_EN
    logic [SIG_W-1:0] cap_q, cap_d;
`endif

    logic sig_match;
    assign sig_match = (misr_sig == golden_sig);

    always_comb begin
        state_d = state_q;
        idx_d   = '0;
        pass_d  = pass_q;
        fail_d  = fail_q;
`ifdef BIST_SIG_CAPTURE_EN
        cap_d   = cap_q;
`endif
        if (abort) begin
            state_d = StIdle;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
            cap_d   = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StClear;
                    end
                end
                StClear: begin
                    state_d = StRun;
                end
                StRun: begin
                    // idx_d defaults to 0 so the counter is already clean when RUN ends
                    if (idx_q == LastIdx) begin
                        state_d = StCheck;
                    end else begin
                        idx_d = idx_q + IdxOne;
                    end
                end
                StCheck: begin
                    state_d = StDone;
                    pass_d  = sig_match;
                    fail_d  = !sig_match;
`ifdef BIST_SIG_CAPTURE_EN
                    cap_d   = misr_sig;
`endif
                end
                StDone: begin
                    if (start) begin
                        state_d = StClear;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            // Results from a previous run are dropped as soon as a new run begins
            if (state_d == StClear) begin
                pass_d = 1'b0;
                fail_d = 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
                cap_d  = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
`ifdef BIST_SIG_CAPTURE_EN
            cap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
`ifdef BIST_SIG_CAPTURE_EN
            cap_q   <= cap_d;
`endif
        end
    end

    assign misr_clear  = (state_q == StClear);
    assign misr_enable = (state_q == StRun);
    assign pattern_adv = (state_q == StRun);
    assign pattern_idx = idx_q;
    assign busy        = (state_q == StClear) || (state_q == StRun) || (state_q == StCheck);
    assign done        = (state_q == StDone);
    assign pass        = pass_q;
    assign fail        = fail_q;
`ifdef BIST_SIG_CAPTURE_EN
    assign sig_captured = cap_q;
`endif

endmodule

// File: tb/tb_bist_sig_checker.sv
// Self-checking bench: three checker instances (N_PATTERNS 2, 1, 8), each driving a behavioural MISR.
module tb_bist_sig_checker;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  start, abort;
    logic [15:0] golden [NDUT];
    logic [15:0] msig [NDUT];
    logic [2:0]  mclr, men, padv, busy, done, pass, fail;
    logic [15:0] pidx [NDUT];
`ifdef BIST_SIG_CAPTURE_EN
    logic [15:0] cap [NDUT];
`endif

    logic [15:0] pat [NDUT][16];
    int          en_cnt [NDUT];
    int          drise [NDUT];
    logic [2:0]  done_prev;
    int          viol;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        bist_sig_checker #(
            .SIG_W      (16),
            .N_PATTERNS (g == 0 ? 2 : (g == 1 ? 1 : 8)),
            .CNT_W      (16)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n),
            .start        (start[g]),
            .abort        (abort[g]),
            .misr_sig     (msig[g]),
            .golden_sig   (golden[g]),
            .misr_clear   (mclr[g]),
            .misr_enable  (men[g]),
            .pattern_adv  (padv[g]),
            .pattern_idx  (pidx[g]),
            .busy         (busy[g]),
            .done         (done[g]),
            .pass         (pass[g]),
`ifdef BIST_SIG_CAPTURE_EN
            .fail         (fail[g]),
            .sig_captured (cap[g])
`else
            .fail         (fail[g])
`endif
        );
    end

    function automatic int np(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 8);
    endfunction

    // One MISR compaction step: shift left, feed back polynomial on MSB, fold in data word
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    // Reference: signature after compacting patterns 0..n-1 into a cleared register
    function automatic logic [15:0] ref_sig(input int g, input int n);
        logic [15:0] s = 16'h0000;
        for (int i = 0; i < n; i++) s = misr_step(s, pat[g][i]);
        return s;
    endfunction

    // Behavioural MISRs fed by the pattern source, plus monitors
    always @(posedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (mclr[g]) msig[g] <= 16'h0000;
            else if (men[g]) msig[g] <= misr_step(msig[g], pat[g][pidx[g][3:0]]);
            if (men[g]) en_cnt[g] <= en_cnt[g] + 1;
            if (done[g] && !done_prev[g]) drise[g] <= drise[g] + 1;
            if ((pass[g] && fail[g]) || (mclr[g] && men[g]) || (padv[g] !== men[g]))
                viol <= viol + 1;
        end
        done_prev <= done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full run from IDLE/DONE; optionally toggles start randomly while busy
    task automatic do_run(input int g, input logic [15:0] gold, input bit toggle, input string tag);
        int          n = np(g);
        logic [15:0] exp_sig = ref_sig(g, n);
        bit          exp_pass = (exp_sig == gold);
        int          en0 = en_cnt[g];
        int          dr0 = drise[g];
        int          k = 0;
        golden[g] = gold;
        start[g]  = 1'b1;
        @(negedge clk);
        check({tag, "_clear"}, {26'd0, mclr[g], men[g], busy[g], done[g], pass[g], fail[g]},
              32'b101000);
        start[g] = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        while (k < n + 10) begin
            @(negedge clk);
            k++;
            if (done[g]) begin
                start[g] = 1'b0;
                break;
            end
            if (k <= n) check({tag, "_run_idx"}, {15'd0, men[g], pidx[g]}, {15'd0, 1'b1, 16'(k - 1)});
            start[g] = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        start[g] = 1'b0;
        // From the start-sampling edge: CLEAR 1 + RUN n + CHECK 1 edges, i.e. edge n+2 (n+3 edges)
        check({tag, "_latency"}, k, n + 2);
        check({tag, "_result"}, {30'd0, pass[g], fail[g]}, exp_pass ? 32'b10 : 32'b01);
        @(negedge clk);
        check({tag, "_en_cycles"}, en_cnt[g] - en0, n);
        check({tag, "_done_once"}, {drise[g] - dr0}, 1);
        check({tag, "_done_hold"}, {29'd0, done[g], pass[g], fail[g]},
              exp_pass ? 32'b110 : 32'b101);
`ifdef BIST_SIG_CAPTURE_EN
        check({tag, "_capture"}, {16'd0, cap[g]}, {16'd0, exp_sig});
`endif
    endtask

    initial begin
        viol      = 0;
        for (int g = 0; g < NDUT; g++) begin
            en_cnt[g] = 0;
            drise[g]  = 0;
        end
        reset_n = 1'b0;
        start   = '0;
        abort   = '0;
        for (int g = 0; g < NDUT; g++) begin
            golden[g] = 16'h0000;
            for (int i = 0; i < 16; i++) pat[g][i] = 16'h0001;
        end
        #1;
        check("reset_ctl", {11'd0, mclr, men, padv, busy, done, pass, fail}, 32'd0);
        check("reset_idx", {pidx[0], pidx[2]}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Constant serial-in of 1: signature 0x0003 after 2 patterns, 0x0001 after 1
        do_run(0, 16'h0003, 1'b0, "t1_pass");
        do_run(0, 16'h0004, 1'b0, "t2_fail");
        do_run(1, 16'h0001, 1'b0, "t3_pass");
        do_run(1, 16'h0001, 1'b0, "t3_rerun");

        // Abort out of DONE clears the results
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        check("abort_done", {29'd0, done[1], pass[1], fail[1]}, 32'd0);

        // Abort mid-run at pattern 3
        for (int i = 0; i < 16; i++) pat[2][i] = 16'($urandom);
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_at_idx3", {16'd0, pidx[2]}, 32'd3);
        abort[2] = 1'b1;
        @(negedge clk);
        check("t4_abort", {12'd0, busy[2], done[2], men[2], mclr[2], pidx[2]}, 32'd0);
        start[2] = 1'b1;
        @(negedge clk);
        check("t4_abort_wins", {30'd0, busy[2], mclr[2]}, 32'd0);
        start[2] = 1'b0;
        abort[2] = 1'b0;
        @(negedge clk);

        // Randomised runs with start toggling while busy
        for (int r = 0; r < 4; r++) begin
            for (int g = 0; g < NDUT; g++) begin
                logic [15:0] gold;
                for (int i = 0; i < 16; i++) pat[g][i] = 16'($urandom);
                gold = ref_sig(g, np(g));
                if ($urandom_range(0, 1) == 1) gold = gold ^ 16'($urandom_range(1, 65535));
                do_run(g, gold, 1'b1, $sformatf("rnd%0d_%0d", r, g));
            end
        end

        // Asynchronous reset mid-RUN, while instance 0 sits in DONE with pass set
        for (int i = 0; i < 16; i++) pat[0][i] = 16'h0001;
        do_run(0, 16'h0003, 1'b0, "t5_pre");
        start[2] = 1'b1;
        @(negedge clk);
        start[2] = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_ctl", {11'd0, mclr, men, padv, busy, done, pass, fail}, 32'd0);
        check("t5_async_idx", {16'd0, pidx[2]}, 32'd0);
`ifdef BIST_SIG_CAPTURE_EN
        check("t5_async_cap", {16'd0, cap[0]}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_run(2, ref_sig(2, 8), 1'b0, "t5_after");

        check("invariants", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
